// File: rtl/unidade_controle_multiciclo.sv
// -----------------------------------------------------------------------------
// unidade_controle_multiciclo
//
// Multi-cycle control FSM for a MIPS datapath. It sequences fetch, decode,
// execute, memory and writeback, and drives every datapath enable from the
// state register (Moore style). Two outputs are exceptions: the BUSCA
// irEscreve/pcEscreve pulse follows the memory handshake, and the DESVIO
// pcEscreve follows the ALU zero flag.
//
// Parameters
//   LAT_MULDIV : cycles spent in ESPERA_MD for mult/div (1..15)
//   LARG_CONT  : width of the mult/div wait counter
//
// Ports
//   clock, reset (async, active-low)
//   opcode, funct    : fields of the instruction register
//   isZero           : ALU result == 0
//   memPronto        : memory access complete
//   ulaOpCode        : ALU op (Add 000 Sub 001 Or 010 Equal 011 Less 100
//                      Mult 101 Div 110 And 111)
//   ulaFonteA/B      : ALU operand selects
//   pcEscreve/pcFonte: PC write enable and source select
//   iOuD, memLe, memEscreve : memory address select and requests
//   irEscreve        : instruction register load
//   regEscreve, regDestino, memParaReg : register file write controls
//   excecao          : illegal instruction (held until reset)
//   estado           : current state, for debug
// -----------------------------------------------------------------------------
module unidade_controle_multiciclo #(
  parameter int LAT_MULDIV = 4,
  parameter int LARG_CONT  = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       isZero,
  input  logic       memPronto,
  output logic [2:0] ulaOpCode,
  output logic       ulaFonteA,
  output logic [1:0] ulaFonteB,
  output logic       pcEscreve,
  output logic [1:0] pcFonte,
  output logic       iOuD,
  output logic       memLe,
  output logic       memEscreve,
  output logic       irEscreve,
  output logic       regEscreve,
  output logic       regDestino,
  output logic       memParaReg,
  output logic       excecao,
  output logic [3:0] estado
);

  typedef enum logic [3:0] {
    INICIO          = 4'd0,
    BUSCA           = 4'd1,
    DECODIFICA      = 4'd2,
    EXEC_R          = 4'd3,
    ESPERA_MD       = 4'd4,
    ESCRITA_R       = 4'd5,
    CALC_END        = 4'd6,
    LE_MEM          = 4'd7,
    ESCRITA_MEM_REG = 4'd8,
    ESCREVE_MEM     = 4'd9,
    DESVIO          = 4'd10,
    SALTO           = 4'd11,
    EXEC_I          = 4'd12,
    ESCRITA_I       = 4'd13,
    INVALIDA        = 4'd14
  } estado_t;

  localparam logic [2:0] ULA_ADD  = 3'b000;
  localparam logic [2:0] ULA_SUB  = 3'b001;
  localparam logic [2:0] ULA_OR   = 3'b010;
  localparam logic [2:0] ULA_EQ   = 3'b011;
  localparam logic [2:0] ULA_LESS = 3'b100;
  localparam logic [2:0] ULA_MULT = 3'b101;
  localparam logic [2:0] ULA_DIV  = 3'b110;
  localparam logic [2:0] ULA_AND  = 3'b111;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_EQ   = 6'b101000;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;

  localparam logic [LARG_CONT-1:0] CONT_FIM = LARG_CONT'(LAT_MULDIV - 1);

  function automatic logic [2:0] op_de_funct(input logic [5:0] f);
    case (f)
      FN_SUB:  op_de_funct = ULA_SUB;
      FN_AND:  op_de_funct = ULA_AND;
      FN_OR:   op_de_funct = ULA_OR;
      FN_SLT:  op_de_funct = ULA_LESS;
      FN_EQ:   op_de_funct = ULA_EQ;
      FN_MULT: op_de_funct = ULA_MULT;
      FN_DIV:  op_de_funct = ULA_DIV;
      default: op_de_funct = ULA_ADD;
    endcase
  endfunction

  function automatic logic funct_valido(input logic [5:0] f);
    case (f)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_EQ, FN_MULT, FN_DIV:
        funct_valido = 1'b1;
      default:
        funct_valido = 1'b0;
    endcase
  endfunction

  estado_t              estado_q, estado_d;
  logic [LARG_CONT-1:0] cont_q, cont_d;
  // ALU op and branch/store flavour are captured in DECODIFICA so that the
  // later states decode purely from registers, and the op stays stable
  // across the whole mult/div wait.
  logic [2:0]           ula_op_q, ula_op_d;
  logic                 eh_bne_q, eh_bne_d;
  logic                 eh_sw_q, eh_sw_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= INICIO;
      cont_q   <= '0;
      ula_op_q <= ULA_ADD;
      eh_bne_q <= 1'b0;
      eh_sw_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cont_q   <= cont_d;
      ula_op_q <= ula_op_d;
      eh_bne_q <= eh_bne_d;
      eh_sw_q  <= eh_sw_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    cont_d   = cont_q;
    ula_op_d = ula_op_q;
    eh_bne_d = eh_bne_q;
    eh_sw_d  = eh_sw_q;
    case (estado_q)
      INICIO: estado_d = BUSCA;
      BUSCA:  if (memPronto) estado_d = DECODIFICA;
      DECODIFICA: begin
        eh_bne_d = (opcode == OP_BNE);
        eh_sw_d  = (opcode == OP_SW);
        case (opcode)
          OP_R: begin
            estado_d = EXEC_R;
            ula_op_d = op_de_funct(funct);
          end
          OP_LW, OP_SW: estado_d = CALC_END;
          OP_BEQ, OP_BNE: estado_d = DESVIO;
          OP_J: estado_d = SALTO;
          OP_ADDI: begin
            estado_d = EXEC_I;
            ula_op_d = ULA_ADD;
          end
          OP_ORI: begin
            estado_d = EXEC_I;
            ula_op_d = ULA_OR;
          end
          OP_SLTI: begin
            estado_d = EXEC_I;
            ula_op_d = ULA_LESS;
          end
          default: estado_d = INVALIDA;
        endcase
      end
      EXEC_R: begin
        if (!funct_valido(funct)) begin
          estado_d = INVALIDA;
        end else if (funct == FN_MULT || funct == FN_DIV) begin
          estado_d = ESPERA_MD;
          cont_d   = '0;
        end else begin
          estado_d = ESCRITA_R;
        end
      end
      ESPERA_MD: begin
        cont_d = cont_q + 1'b1;
        if (cont_q == CONT_FIM) estado_d = ESCRITA_R;
      end
      ESCRITA_R:       estado_d = BUSCA;
      CALC_END:        estado_d = eh_sw_q ? ESCREVE_MEM : LE_MEM;
      LE_MEM:          if (memPronto) estado_d = ESCRITA_MEM_REG;
      ESCRITA_MEM_REG: estado_d = BUSCA;
      ESCREVE_MEM:     if (memPronto) estado_d = BUSCA;
      DESVIO:          estado_d = BUSCA;
      SALTO:           estado_d = BUSCA;
      EXEC_I:          estado_d = ESCRITA_I;
      ESCRITA_I:       estado_d = BUSCA;
      INVALIDA:        estado_d = INVALIDA;
      default:         estado_d = INICIO;
    endcase
  end

  always_comb begin
    ulaOpCode  = ULA_ADD;
    ulaFonteA  = 1'b0;
    ulaFonteB  = 2'b00;
    pcEscreve  = 1'b0;
    pcFonte    = 2'b00;
    iOuD       = 1'b0;
    memLe      = 1'b0;
    memEscreve = 1'b0;
    irEscreve  = 1'b0;
    regEscreve = 1'b0;
    regDestino = 1'b0;
    memParaReg = 1'b0;
    excecao    = 1'b0;
    case (estado_q)
      BUSCA: begin
        memLe     = 1'b1;
        ulaFonteB = 2'b01;
        // IR load and PC+4 happen only on the handshake cycle
        irEscreve = memPronto;
        pcEscreve = memPronto;
      end
      DECODIFICA: ulaFonteB = 2'b11;
      EXEC_R, ESPERA_MD: begin
        ulaFonteA = 1'b1;
        ulaOpCode = ula_op_q;
      end
      ESCRITA_R: begin
        regEscreve = 1'b1;
        regDestino = 1'b1;
      end
      CALC_END: begin
        ulaFonteA = 1'b1;
        ulaFonteB = 2'b10;
      end
      LE_MEM: begin
        memLe = 1'b1;
        iOuD  = 1'b1;
      end
      ESCRITA_MEM_REG: begin
        regEscreve = 1'b1;
        memParaReg = 1'b1;
      end
      ESCREVE_MEM: begin
        memEscreve = 1'b1;
        iOuD       = 1'b1;
      end
      DESVIO: begin
        ulaFonteA = 1'b1;
        ulaOpCode = ULA_SUB;
        pcFonte   = 2'b01;
        pcEscreve = eh_bne_q ? !isZero : isZero;
      end
      SALTO: begin
        pcEscreve = 1'b1;
        pcFonte   = 2'b10;
      end
      EXEC_I: begin
        ulaFonteA = 1'b1;
        ulaFonteB = 2'b10;
        ulaOpCode = ula_op_q;
      end
      ESCRITA_I: regEscreve = 1'b1;
      INVALIDA:  excecao = 1'b1;
      default: ;
    endcase
  end

  assign estado = estado_q;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
module tb_unidade_controle_multiciclo;

  logic       clock;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       isZero;
  logic       memPronto;
  logic [2:0] ulaOpCode;
  logic       ulaFonteA;
  logic [1:0] ulaFonteB;
  logic       pcEscreve;
  logic [1:0] pcFonte;
  logic       iOuD;
  logic       memLe;
  logic       memEscreve;
  logic       irEscreve;
  logic       regEscreve;
  logic       regDestino;
  logic       memParaReg;
  logic       excecao;
  logic [3:0] estado;

  unidade_controle_multiciclo #(.LAT_MULDIV(4), .LARG_CONT(4)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
    .isZero(isZero), .memPronto(memPronto), .ulaOpCode(ulaOpCode),
    .ulaFonteA(ulaFonteA), .ulaFonteB(ulaFonteB), .pcEscreve(pcEscreve),
    .pcFonte(pcFonte), .iOuD(iOuD), .memLe(memLe), .memEscreve(memEscreve),
    .irEscreve(irEscreve), .regEscreve(regEscreve), .regDestino(regDestino),
    .memParaReg(memParaReg), .excecao(excecao), .estado(estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {op, fa, fb, pcw, pcf, iord, memLe, memW, irW, regW, regD, m2r, exc}
  logic [16:0] out_vec;
  assign out_vec = {ulaOpCode, ulaFonteA, ulaFonteB, pcEscreve, pcFonte, iOuD,
                    memLe, memEscreve, irEscreve, regEscreve, regDestino,
                    memParaReg, excecao};

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        iz;
    logic        mp;
    logic [3:0]  st;
    logic [16:0] out;
  } vec_t;

  vec_t tab[$];
  int checks = 0;
  int passes = 0;

  function automatic logic [16:0] mk(input logic [2:0] op, input logic fa,
      input logic [1:0] fb, input logic pcw, input logic [1:0] pcf,
      input logic iord, input logic ml, input logic mw, input logic irw,
      input logic rw, input logic rd, input logic m2r, input logic exc);
    mk = {op, fa, fb, pcw, pcf, iord, ml, mw, irw, rw, rd, m2r, exc};
  endfunction

  function automatic logic [16:0] e_busca(input logic pulso);
    e_busca = mk(3'b000, 0, 2'b01, pulso, 2'b00, 0, 1, 0, pulso, 0, 0, 0, 0);
  endfunction
  function automatic logic [16:0] e_dec();
    e_dec = mk(3'b000, 0, 2'b11, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [16:0] e_exr(input logic [2:0] op);
    e_exr = mk(op, 1, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [16:0] e_escr();
    e_escr = mk(3'b000, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0);
  endfunction
  function automatic logic [16:0] e_calc();
    e_calc = mk(3'b000, 1, 2'b10, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [16:0] e_le();
    e_le = mk(3'b000, 0, 2'b00, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [16:0] e_emr();
    e_emr = mk(3'b000, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0);
  endfunction
  function automatic logic [16:0] e_em();
    e_em = mk(3'b000, 0, 2'b00, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [16:0] e_des(input logic pcw);
    e_des = mk(3'b001, 1, 2'b00, pcw, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [16:0] e_salto();
    e_salto = mk(3'b000, 0, 2'b00, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [16:0] e_exi(input logic [2:0] op);
    e_exi = mk(op, 1, 2'b10, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [16:0] e_esci();
    e_esci = mk(3'b000, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0);
  endfunction

  task automatic push(input logic [5:0] op, input logic [5:0] fn,
                      input logic iz, input logic mp, input logic [3:0] st,
                      input logic [16:0] out);
    vec_t v;
    v.op = op; v.fn = fn; v.iz = iz; v.mp = mp; v.st = st; v.out = out;
    tab.push_back(v);
  endtask

  // nwait BUSCA cycles without handshake, the handshake cycle, then DECODIFICA
  // (memPronto high there, which must be ignored).
  task automatic fetch(input logic [5:0] op, input logic [5:0] fn, input int nwait);
    for (int i = 0; i < nwait; i++) push(op, fn, 0, 0, 4'd1, e_busca(0));
    push(op, fn, 0, 1, 4'd1, e_busca(1));
    push(op, fn, 0, 1, 4'd2, e_dec());
  endtask

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nome, act, exp);
  endtask

  task automatic apply(input vec_t v, input string nome);
    opcode = v.op; funct = v.fn; isZero = v.iz; memPronto = v.mp;
    #1;
    chk({nome, " estado"}, 32'(estado), 32'(v.st));
    chk({nome, " saidas"}, 32'(out_vec), 32'(v.out));
    @(posedge clock); #1;
  endtask

  task automatic run_tab(input string pre);
    for (int i = 0; i < tab.size(); i++) apply(tab[i], $sformatf("%s[%0d]", pre, i));
    tab.delete();
  endtask

  logic [5:0] r_fn[5] = '{6'h22, 6'h24, 6'h25, 6'h2A, 6'h28};
  logic [2:0] r_op[5] = '{3'b001, 3'b111, 3'b010, 3'b100, 3'b011};

  initial begin
    reset = 1'b0; opcode = 6'h00; funct = 6'h20; isZero = 1'b0; memPronto = 1'b1;

    // ---- Reset held: state 0 and every output low
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk("reset estado", 32'(estado), 32'd0);
      chk("reset saidas", 32'(out_vec), 32'd0);
    end
    reset = 1'b1;

    // ---- Directed vector table
    push(6'h00, 6'h20, 0, 1, 4'd0, 17'd0);                 // INICIO one cycle
    fetch(6'h00, 6'h20, 0);                                // add
    push(6'h00, 6'h20, 0, 1, 4'd3, e_exr(3'b000));
    push(6'h00, 6'h20, 0, 1, 4'd5, e_escr());
    fetch(6'h23, 6'h00, 1);                                // lw, late fetch
    push(6'h23, 6'h00, 0, 1, 4'd6, e_calc());
    push(6'h23, 6'h00, 0, 0, 4'd7, e_le());
    push(6'h23, 6'h00, 0, 0, 4'd7, e_le());
    push(6'h23, 6'h00, 0, 1, 4'd7, e_le());
    push(6'h23, 6'h00, 0, 0, 4'd8, e_emr());
    fetch(6'h2B, 6'h00, 0);                                // sw
    push(6'h2B, 6'h00, 0, 1, 4'd6, e_calc());
    push(6'h2B, 6'h00, 0, 0, 4'd9, e_em());
    push(6'h2B, 6'h00, 0, 1, 4'd9, e_em());
    fetch(6'h04, 6'h00, 0); push(6'h04, 6'h00, 1, 0, 4'd10, e_des(1)); // beq taken
    fetch(6'h04, 6'h00, 0); push(6'h04, 6'h00, 0, 0, 4'd10, e_des(0)); // beq not
    fetch(6'h05, 6'h00, 0); push(6'h05, 6'h00, 1, 0, 4'd10, e_des(0)); // bne not
    fetch(6'h05, 6'h00, 0); push(6'h05, 6'h00, 0, 0, 4'd10, e_des(1)); // bne taken
    fetch(6'h02, 6'h00, 0); push(6'h02, 6'h00, 0, 0, 4'd11, e_salto()); // j
    fetch(6'h08, 6'h00, 0);                                // addi
    push(6'h08, 6'h00, 0, 0, 4'd12, e_exi(3'b000));
    push(6'h08, 6'h00, 0, 0, 4'd13, e_esci());
    fetch(6'h0D, 6'h00, 0);                                // ori
    push(6'h0D, 6'h00, 0, 0, 4'd12, e_exi(3'b010));
    push(6'h0D, 6'h00, 0, 0, 4'd13, e_esci());
    fetch(6'h0A, 6'h00, 0);                                // slti
    push(6'h0A, 6'h00, 0, 0, 4'd12, e_exi(3'b100));
    push(6'h0A, 6'h00, 0, 0, 4'd13, e_esci());
    fetch(6'h00, 6'h18, 0);                                // mult: 4 wait cycles
    push(6'h00, 6'h18, 0, 1, 4'd3, e_exr(3'b101));
    for (int i = 0; i < 4; i++) push(6'h00, 6'h18, 0, 1, 4'd4, e_exr(3'b101));
    push(6'h00, 6'h18, 0, 0, 4'd5, e_escr());
    fetch(6'h00, 6'h1A, 0);                                // div
    push(6'h00, 6'h1A, 0, 1, 4'd3, e_exr(3'b110));
    for (int i = 0; i < 4; i++) push(6'h00, 6'h1A, 0, 1, 4'd4, e_exr(3'b110));
    push(6'h00, 6'h1A, 0, 0, 4'd5, e_escr());
    for (int k = 0; k < 5; k++) begin                      // remaining R ops
      fetch(6'h00, r_fn[k], 0);
      push(6'h00, r_fn[k], 0, 0, 4'd3, e_exr(r_op[k]));
      push(6'h00, r_fn[k], 0, 0, 4'd5, e_escr());
    end
    run_tab("tab");

    // ---- bne: pcEscreve follows isZero within one DESVIO cycle
    fetch(6'h05, 6'h00, 0);
    run_tab("bne");
    isZero = 1'b0; #1;
    chk("desvio estado", 32'(estado), 32'd10);
    chk("bne iz0 pcEscreve", 32'(pcEscreve), 32'd1);
    isZero = 1'b1; #1;
    chk("bne iz1 pcEscreve", 32'(pcEscreve), 32'd0);
    @(posedge clock); #1;

    // ---- reset while ESCREVE_MEM is held: request drops before next edge
    fetch(6'h2B, 6'h00, 0);
    push(6'h2B, 6'h00, 0, 0, 4'd6, e_calc());
    run_tab("sw");
    memPronto = 1'b0; #1;
    chk("sw held estado", 32'(estado), 32'd9);
    chk("sw held memEscreve", 32'(memEscreve), 32'd1);
    reset = 1'b0; #1;
    chk("abort memEscreve", 32'(memEscreve), 32'd0);
    chk("abort memLe", 32'(memLe), 32'd0);
    chk("abort estado", 32'(estado), 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;

    // ---- illegal opcode: INVALIDA is sticky
    push(6'h3F, 6'h00, 0, 1, 4'd0, 17'd0);
    fetch(6'h3F, 6'h00, 0);
    run_tab("ilegal");
    for (int i = 0; i < 20; i++) begin
      memPronto = i[0]; isZero = i[1]; #1;
      chk($sformatf("invalida estado %0d", i), 32'(estado), 32'd14);
      chk($sformatf("invalida saidas %0d", i), 32'(out_vec), 32'd1);
      @(posedge clock); #1;
    end
    reset = 1'b0; #1;
    chk("excecao cleared", 32'(excecao), 32'd0);
    chk("estado after reset", 32'(estado), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
